// File: rtl/proc_test_harness_if.sv
// Bus between the processor test harness and its environment: program image ROM,
// expected-value ROM, processor memory write port, processor control/observation
// and run status.
interface proc_test_harness_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] img_addr;
    logic [DATA_W-1:0] img_data;
    logic [7:0]        exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_rst;
    logic [DATA_W-1:0] cpu_out_port;
    logic              cpu_hlt;
    logic              busy;
    logic              done;
    logic              pass;
    logic [7:0]        match_cnt;
    logic [7:0]        mismatch_cnt;

    // Harness side
    modport master (
        input  start, img_data, exp_data, cpu_out_port, cpu_hlt,
        output img_addr, exp_addr, mem_we, mem_addr, mem_wdata, cpu_rst,
               busy, done, pass, match_cnt, mismatch_cnt
    );

    // Environment side
    modport slave (
        output start, img_data, exp_data, cpu_out_port, cpu_hlt,
        input  img_addr, exp_addr, mem_we, mem_addr, mem_wdata, cpu_rst,
               busy, done, pass, match_cnt, mismatch_cnt
    );
endinterface

// File: rtl/proc_test_harness.sv
// Processor test harness: copies a program image into processor memory while the
// processor is held in reset, releases it, then compares each change on the
// processor output port against a table of expected values.
// Optional RUN watchdog enabled by defining PROC_TEST_HARNESS_TIMEOUT_EN.
module proc_test_harness #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned N_EXP      = 16,
    parameter int unsigned RST_CYCLES = 3,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                i_clk,
    input  logic                i_rst,
    proc_test_harness_if.master io_bus
);

    // LOAD counts 0..2^ADDR_W: one extra cycle drains the 1-cycle ROM latency
    localparam int unsigned LoadLast = 1 << ADDR_W;
    localparam int unsigned CntMaxA  = (LoadLast > RST_CYCLES) ? LoadLast : RST_CYCLES;
    localparam int unsigned CntMax   = (CntMaxA > TIMEOUT) ? CntMaxA : TIMEOUT;
    localparam int unsigned CntW     = $clog2(CntMax + 1);

    localparam logic [CntW-1:0] LoadLastC = CntW'(LoadLast);
    localparam logic [CntW-1:0] HoldLastC = CntW'(RST_CYCLES - 1);
    localparam logic [8:0]      NExpC     = 9'(N_EXP);

    typedef enum logic [2:0] {StIdle, StLoad, StHold, StRun, StDone} state_e;

    state_e            r_state, w_state_nxt;
    logic [CntW-1:0]   r_cnt, w_cnt_nxt;
    logic              r_cpu_rst, w_cpu_rst_nxt;
    logic [DATA_W-1:0] r_out, w_out_nxt;
    logic              r_first, w_first_nxt;
    logic [8:0]        r_idx, w_idx_nxt;
    logic [7:0]        r_match, w_match_nxt;
    logic [7:0]        r_mis, w_mis_nxt;
    logic              r_done, w_done_nxt;
    logic              r_pass, w_pass_nxt;
    logic              w_event;
    logic              w_end;
    logic              w_mem_we;

    // State and datapath registers; reset forces the idle, processor-held state
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_cpu_rst <= 1'b0;
            r_out     <= '0;
            r_first   <= 1'b0;
            r_idx     <= '0;
            r_match   <= '0;
            r_mis     <= '0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_cpu_rst <= w_cpu_rst_nxt;
            r_out     <= w_out_nxt;
            r_first   <= w_first_nxt;
            r_idx     <= w_idx_nxt;
            r_match   <= w_match_nxt;
            r_mis     <= w_mis_nxt;
            r_done    <= w_done_nxt;
            r_pass    <= w_pass_nxt;
        end
    end

    // Next-state, event detection and scoring
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cpu_rst_nxt = r_cpu_rst;
        w_out_nxt     = r_out;
        w_first_nxt   = r_first;
        w_idx_nxt     = r_idx;
        w_match_nxt   = r_match;
        w_mis_nxt     = r_mis;
        w_done_nxt    = r_done;
        w_pass_nxt    = r_pass;
        w_event       = 1'b0;
        w_end         = 1'b0;
        unique case (r_state)
            StIdle, StDone: begin
                if (io_bus.start) begin
                    w_state_nxt   = StLoad;
                    w_cnt_nxt     = '0;
                    w_cpu_rst_nxt = 1'b0;
                    w_idx_nxt     = '0;
                    w_match_nxt   = '0;
                    w_mis_nxt     = '0;
                    w_done_nxt    = 1'b0;
                    w_pass_nxt    = 1'b0;
                end
            end
            StLoad: begin
                if (r_cnt == LoadLastC) begin
                    w_state_nxt = StHold;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StHold: begin
                if (r_cnt == HoldLastC) begin
                    w_state_nxt   = StRun;
                    w_cnt_nxt     = '0;
                    w_cpu_rst_nxt = 1'b1;
                    w_first_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StRun: begin
                w_out_nxt   = io_bus.cpu_out_port;
                w_first_nxt = 1'b0;
                // First RUN cycle only establishes the baseline value
                w_event     = !r_first && (io_bus.cpu_out_port != r_out);
                if (w_event) begin
                    if (io_bus.cpu_out_port == io_bus.exp_data) begin
                        if (r_match != 8'hFF) w_match_nxt = r_match + 8'd1;
                    end else begin
                        if (r_mis != 8'hFF) w_mis_nxt = r_mis + 8'd1;
                    end
                    w_idx_nxt = r_idx + 9'd1;
                end
                w_end = (w_idx_nxt == NExpC) || io_bus.cpu_hlt;
`ifdef PROC_TEST_HARNESS_TIMEOUT_EN
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CntW'(TIMEOUT - 1)) w_end = 1'b1;
`endif
                if (w_end) begin
                    w_state_nxt = StDone;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = (w_mis_nxt == 8'd0) && (w_idx_nxt == NExpC);
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign w_mem_we = (r_state == StLoad) && (r_cnt != '0);

    assign io_bus.img_addr     = (r_state == StLoad) ? r_cnt[ADDR_W-1:0] : '0;
    assign io_bus.mem_we       = w_mem_we;
    // Write address trails the ROM address by the ROM read latency
    assign io_bus.mem_addr     = w_mem_we ? ADDR_W'(r_cnt - 1'b1) : '0;
    assign io_bus.mem_wdata    = w_mem_we ? io_bus.img_data : '0;
    assign io_bus.exp_addr     = (r_state == StRun) ? r_idx[7:0] : 8'd0;
    assign io_bus.cpu_rst      = r_cpu_rst;
    assign io_bus.busy         = (r_state == StLoad) || (r_state == StHold) ||
                                 (r_state == StRun);
    assign io_bus.done         = r_done;
    assign io_bus.pass         = r_pass;
    assign io_bus.match_cnt    = r_match;
    assign io_bus.mismatch_cnt = r_mis;

endmodule

// File: tb/tb_proc_test_harness.sv
// Directed bench for proc_test_harness: image load, matching run, mismatching run,
// halt, reset mid-load and (with PROC_TEST_HARNESS_TIMEOUT_EN) the RUN watchdog.
module tb_proc_test_harness;

    localparam int unsigned DataW     = 8;
    localparam int unsigned AddrW     = 4;
    localparam int unsigned NExp      = 3;
    localparam int unsigned RstCycles = 3;
    localparam int unsigned Timeout   = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [7:0] rom [16];

    proc_test_harness_if #(.DATA_W(DataW), .ADDR_W(AddrW)) bus ();

    proc_test_harness #(
        .DATA_W    (DataW),
        .ADDR_W    (AddrW),
        .N_EXP     (NExp),
        .RST_CYCLES(RstCycles),
        .TIMEOUT   (Timeout)
    ) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus)
    );

    always #5 clk = ~clk;

    // Synchronous image ROM, 1-cycle latency
    always @(posedge clk) bus.img_data <= rom[bus.img_addr];

    // Combinational expected-value ROM {AB, CD, 55}
    always_comb begin
        case (bus.exp_addr)
            8'd0:    bus.exp_data = 8'hAB;
            8'd1:    bus.exp_data = 8'hCD;
            8'd2:    bus.exp_data = 8'h55;
            default: bus.exp_data = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        for (int k = 0; k < 60; k++) begin
            if (bus.cpu_rst === 1'b1) break;
            tick();
        end
        check(tag, bus.cpu_rst, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_pass"}, bus.pass, 0);
        check({tag, "_cpu_rst"}, bus.cpu_rst, 0);
        check({tag, "_mem_we"}, bus.mem_we, 0);
        check({tag, "_img_addr"}, bus.img_addr, 0);
        check({tag, "_exp_addr"}, bus.exp_addr, 0);
        check({tag, "_match"}, bus.match_cnt, 0);
        check({tag, "_mismatch"}, bus.mismatch_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int nwr;
        int low;
        for (int i = 0; i < 16; i++) rom[i] = 8'(i);
        bus.start        = 1'b0;
        bus.cpu_out_port = 8'h00;
        bus.cpu_hlt      = 1'b0;

        // Reset state
        rst = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();
        check("idle_cpu_rst", bus.cpu_rst, 0);

        // Run 1: image load, then all-matching events
        start_run();
        check("load_busy", bus.busy, 1);
        check("load_first_we", bus.mem_we, 0);
        nwr = 0;
        low = 0;
        for (int k = 0; k < 60; k++) begin
            if (bus.cpu_rst === 1'b1) break;
            if (bus.mem_we === 1'b1) begin
                check("load_addr", bus.mem_addr, nwr);
                check("load_data", bus.mem_wdata, rom[nwr % 16]);
                nwr++;
            end
            if (bus.busy === 1'b1) low++;
            tick();
        end
        check("load_writes", nwr, 16);
        check("cpu_rst_low_cycles", low, 20);
        check("run_entered", bus.cpu_rst, 1);
        check("run_exp_addr0", bus.exp_addr, 0);
        tick();
        bus.cpu_out_port = 8'hAB;
        tick();
        check("r1_match_after_ab", bus.match_cnt, 1);
        check("r1_exp_addr1", bus.exp_addr, 1);
        tick();
        check("r1_unchanged_no_event", bus.match_cnt, 1);
        bus.cpu_out_port = 8'hCD;
        tick();
        bus.cpu_out_port = 8'h55;
        tick();
        check("r1_done", bus.done, 1);
        check("r1_pass", bus.pass, 1);
        check("r1_match", bus.match_cnt, 3);
        check("r1_mismatch", bus.mismatch_cnt, 0);
        check("r1_busy", bus.busy, 0);
        tick();
        check("r1_done_hold", bus.done, 1);

        // Run 2: second value wrong; baseline differs from last registered value
        bus.cpu_out_port = 8'h00;
        start_run();
        check("r2_done_clr", bus.done, 0);
        check("r2_pass_clr", bus.pass, 0);
        check("r2_match_clr", bus.match_cnt, 0);
        check("r2_cpu_rst", bus.cpu_rst, 0);
        wait_run("r2_run");
        tick();
        check("r2_baseline_match", bus.match_cnt, 0);
        check("r2_baseline_mismatch", bus.mismatch_cnt, 0);
        bus.cpu_out_port = 8'hAB;
        tick();
        bus.cpu_out_port = 8'hCE;
        tick();
        bus.cpu_out_port = 8'h55;
        tick();
        check("r2_done", bus.done, 1);
        check("r2_pass", bus.pass, 0);
        check("r2_match", bus.match_cnt, 2);
        check("r2_mismatch", bus.mismatch_cnt, 1);

        // Run 3: halt after one matching event
        bus.cpu_out_port = 8'h00;
        start_run();
        wait_run("r3_run");
        tick();
        bus.cpu_out_port = 8'hAB;
        tick();
        check("r3_match_pre_hlt", bus.match_cnt, 1);
        check("r3_not_done", bus.done, 0);
        bus.cpu_hlt = 1'b1;
        tick();
        bus.cpu_hlt = 1'b0;
        check("r3_done", bus.done, 1);
        check("r3_pass", bus.pass, 0);
        check("r3_match", bus.match_cnt, 1);
        check("r3_mismatch", bus.mismatch_cnt, 0);

        // Reset asserted mid-LOAD
        bus.cpu_out_port = 8'h00;
        start_run();
        repeat (5) tick();
        check("midload_we", bus.mem_we, 1);
        check("midload_busy", bus.busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midload_rst");
        tick();
        rst = 1'b1;
        repeat (3) tick();
        check("post_rst_cpu_rst", bus.cpu_rst, 0);
        check("post_rst_busy", bus.busy, 0);

`ifdef PROC_TEST_HARNESS_TIMEOUT_EN
        // Watchdog: static output port, RUN ends after exactly Timeout cycles
        start_run();
        wait_run("to_run");
        repeat (19) tick();
        check("to_not_done_19", bus.done, 0);
        tick();
        check("to_done_20", bus.done, 1);
        check("to_pass", bus.pass, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/proc_test_harness.md
PROC_TEST_HARNESS -- requirements
Module: proc_test_harness

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning processor data/port width.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning memory address width; the image depth is 2^ADDR_W words.
REQ-003 SHALL have parameter N_EXP, default 16, meaning the number of expected output-port values (1..256).
REQ-004 SHALL have parameter RST_CYCLES, default 3, meaning the number of cycles `cpu_rst` is held low (>=1).
REQ-005 SHALL have parameter TIMEOUT, default 1024, meaning the RUN watchdog limit in cycles.
REQ-006 SHALL have port: clk  in  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port: start  in  1  one-cycle pulse that begins a test run.
REQ-009 SHALL have ports: img_addr  out  ADDR_W; img_data  in  DATA_W; program image ROM read, synchronous, 1-cycle latency.
REQ-010 SHALL have ports: exp_addr  out  8; exp_data  in  DATA_W; expected-value ROM read, combinational.
REQ-011 SHALL have ports: mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; processor memory write port.
REQ-012 SHALL have ports: cpu_rst  out  1  processor reset, active-low; cpu_out_port  in  DATA_W; cpu_hlt  in  1.
REQ-013 SHALL have outputs: busy 1; done 1; pass 1; match_cnt 8; mismatch_cnt 8.

Function
REQ-014 SHALL implement states IDLE, LOAD, HOLD, RUN, DONE, with IDLE entered at reset.
REQ-015 SHALL, in IDLE with start=1, go to LOAD, clear both counters, clear done/pass and drive cpu_rst=0; start is ignored in all other states.
REQ-016 SHALL, in LOAD, step img_addr 0..2^ADDR_W-1 and one cycle later assert mem_we with mem_addr equal to the previous img_addr and mem_wdata=img_data; LOAD lasts exactly 2^ADDR_W+1 cycles.
REQ-017 SHALL keep cpu_rst=0 throughout LOAD and HOLD; HOLD lasts exactly RST_CYCLES cycles, then the block enters RUN with cpu_rst=1.
REQ-018 SHALL, in RUN, register cpu_out_port every cycle, and the first RUN cycle SHALL capture the baseline without comparing.
REQ-019 SHALL treat a RUN cycle where cpu_out_port differs from its registered value as an output event: compare it with exp_data at exp_addr=event index, increment match_cnt or mismatch_cnt, then increment the index; an unchanged value is not an event.
REQ-020 SHALL leave RUN for DONE when the event index reaches N_EXP, or on cpu_hlt=1; if both occur in the same cycle, that cycle's event is still counted.
REQ-021 SHALL, on entering DONE, set done=1 and pass=1 only if mismatch_cnt==0 and the event index==N_EXP; DONE SHALL return to IDLE on the next start, which also begins a new run.
REQ-022 SHALL saturate counters at 255.
REQ-023 SHALL set busy=1 in LOAD, HOLD and RUN, and 0 otherwise.
REQ-024 SHALL drive mem_we=0 outside LOAD.

Reset
REQ-025 SHALL, on rst=0 at any time including mid-run, immediately force: state IDLE, cpu_rst=0, mem_we=0, img_addr=0, exp_addr=0, busy=0, done=0, pass=0, counters=0.
REQ-026 SHALL, after rst deasserts, keep cpu_rst=0 until a completed LOAD/HOLD sequence.

Configuration
REQ-027 SHALL, with macro PROC_TEST_HARNESS_TIMEOUT_EN defined, count cycles in RUN and go to DONE with pass=0 when the count reaches TIMEOUT; without the macro, no watchdog logic SHALL exist and RUN ends only per REQ-020.

Verification
REQ-028 SHALL verify: ADDR_W=4 image 0x00..0x0F, start pulse -> 16 writes mem_addr 0..15 with matching data, cpu_rst low for LOAD+3 cycles.
REQ-029 SHALL verify: N_EXP=3, exp {0xAB,0xCD,0x55}, cpu_out_port steps 0x00->0xAB->0xCD->0x55 -> done=1, pass=1, match_cnt=3, mismatch_cnt=0.
REQ-030 SHALL verify: same run with the second value 0xCE -> pass=0, match_cnt=2, mismatch_cnt=1.
REQ-031 SHALL verify: cpu_hlt=1 after one matching event, N_EXP=3 -> done=1, pass=0, match_cnt=1.
REQ-032 SHALL verify: rst=0 asserted mid-LOAD -> all outputs at reset values within the same cycle; mem_we=0.
REQ-033 SHALL verify: with TIMEOUT_EN defined, TIMEOUT=20, static cpu_out_port -> done=1, pass=0 exactly 20 RUN cycles after entry.
